pim_sequencer: RTL and testbench
================================

Name: pim_sequencer

Overview:
- Program sequencer for the PIM controller; sits directly downstream of the 7-flag condition multiplexer.
- Fetches control instructions from a synchronous instruction memory and drives the 3-bit condition select (cond_sel). It takes back the selected condition bit (cond) in the same cycle.
- Handles conditional jumps, call/return, one hardware loop, flag waits, and EXEC hand-off to the PIM datapath.
- cond_sel value 3'b111 means "always true".

Parameters:
- ADDR_W, 8, instruction address width; also the width of the loop counter.
- STACK_DEPTH, 4, return-stack entries.
- INSTR_W, 6+ADDR_W, instruction word width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution at start_addr; ignored while busy.
- start_addr  in  ADDR_W  first instruction address.
- imem_en  out  1  instruction read strobe.
- imem_addr  out  ADDR_W  read address.
- imem_rdata  in  INSTR_W  instruction word; valid one cycle after imem_en.
- cond_sel  out  3  condition select to the flag multiplexer.
- cond  in  1  selected condition bit, combinational return.
- exec_valid  out  1  EXEC instruction offered to the datapath.
- exec_instr  out  INSTR_W  instruction word held while exec_valid=1.
- exec_done  in  1  datapath completion.
- busy  out  1  high from the cycle after start until return to IDLE.
- done  out  1  one-cycle pulse on HALT.
- error  out  1  sticky; cleared by the next accepted start.
- pc  out  ADDR_W  current program counter.

Behaviour:
- Reset values: all outputs 0, cond_sel=3'b111, state=IDLE, stack pointer=0, loop counter=0.
- Instruction word layout:
  - [2:0] op
  - [5:3] sel
  - [INSTR_W-1:6] target/count
- Opcodes:
  - 0 EXEC, 1 JMP, 2 CALL, 3 RET, 4 LOOP, 5 ENDLOOP, 6 WAIT, 7 HALT.
- States: IDLE, FETCH, DECODE, EXEC_WAIT, WAIT_COND.
- IDLE:
  - start=1 → pc=start_addr, error=0, busy=1, go to FETCH.
- FETCH (1 cycle):
  - imem_en=1, imem_addr=pc, then DECODE.
- DECODE:
  - cond_sel=sel field, driven combinationally from imem_rdata; cond is sampled this cycle only.
  - Outside DECODE and WAIT_COND, cond_sel=3'b111.
- EXEC:
  - Register exec_valid=1 and exec_instr=imem_rdata, go to EXEC_WAIT.
  - In EXEC_WAIT: exec_done=1 → exec_valid=0 next cycle, pc=pc+1, go to FETCH.
  - exec_done outside EXEC_WAIT is ignored.
- JMP: cond=1 → pc=target; else pc=pc+1.
- CALL: cond=1 → push pc+1, pc=target; else pc=pc+1.
  - Push when the stack is full → error=1, done pulse, go to IDLE.
- RET: cond=1 → pc=pop; else pc=pc+1.
  - Pop when the stack is empty → error=1, done pulse, go to IDLE.
- LOOP: loop_cnt=count (0 treated as 1), loop_start=pc+1, pc=pc+1.
  - Single level; a nested LOOP overwrites the previous one.
- ENDLOOP:
  - loop_cnt>1 → loop_cnt-1, pc=loop_start.
  - Otherwise loop_cnt=0, pc=pc+1.
- WAIT: go to WAIT_COND with cond_sel held at the sel field.
  - Leave on the first cycle cond=1 → pc=pc+1, go to FETCH.
  - sel=7 exits on the first WAIT_COND cycle.
- HALT: done=1 for one cycle, busy=0, go to IDLE; pc retains the HALT address.
- Timing:
  - A non-EXEC, non-WAIT instruction costs 2 cycles (FETCH+DECODE).
  - EXEC costs 3 cycles plus datapath latency.
- pc+1 and stack addresses wrap modulo 2^ADDR_W.
- start while busy is ignored.
- Reset mid-operation returns immediately to reset values: exec_valid drops and the stack is emptied.

Decomposition:
- Package pim_seq_pkg holds:
  - opcode enum
  - state enum
  - instruction field bit positions
  - SEL_ALWAYS=3'b111
- One sub-module: pim_ret_stack, a LIFO of STACK_DEPTH x ADDR_W.
  - Inputs: push, pop.
  - Outputs: full, empty, top.
  - Same clk/rst.

Test Plan:
- Reset then start with start_addr=8'h10, where imem[0x10]=HALT → imem_en high with addr 0x10 in cycle 1; done pulse in cycle 2; busy=0 after; pc=0x10.
- JMP with sel=2 and target=0x40:
  - cond=0 → next fetch address 0x11.
  - cond=1 → next fetch address 0x40.
  - sel=7 → jump regardless of cond.
- CALL at 0x05 to target 0x30, RET at 0x30 → next fetch 0x06.
  - Five nested CALLs with STACK_DEPTH=4 → error=1, done pulse, IDLE.
  - RET on an empty stack → error=1.
- LOOP with count=3, body EXEC, ENDLOOP → exactly 3 exec_valid handshakes, then fall-through.
  - count=0 → exactly 1 handshake.
- EXEC with exec_done delayed 5 cycles → exec_valid high for 5 cycles and exec_instr stable; stray exec_done in IDLE has no effect.
- WAIT with sel=4, cond raised after 7 cycles → WAIT_COND held 7 cycles, cond_sel=4 throughout.
  - Assert rst during EXEC_WAIT → exec_valid=0, busy=0 immediately.

Source files
------------

// File: rtl/pim_seq_pkg.sv
// rtl/pim_seq_pkg.sv - shared types and instruction field positions for the PIM sequencer
package pim_seq_pkg;

  typedef enum logic [2:0] {
    OP_EXEC    = 3'd0,
    OP_JMP     = 3'd1,
    OP_CALL    = 3'd2,
    OP_RET     = 3'd3,
    OP_LOOP    = 3'd4,
    OP_ENDLOOP = 3'd5,
    OP_WAIT    = 3'd6,
    OP_HALT    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC_WAIT = 3'd3,
    ST_WAIT_COND = 3'd4
  } state_e;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 2;
  localparam int SEL_LSB = 3;
  localparam int SEL_MSB = 5;
  localparam int ARG_LSB = 6;

  localparam logic [2:0] SEL_ALWAYS = 3'b111;

endpackage

// File: rtl/pim_ret_stack.sv
// rtl/pim_ret_stack.sv - LIFO of return addresses for CALL/RET
module pim_ret_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] top
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [SLOTS];
  logic [ADDR_W-1:0] mem_d [SLOTS];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  wr_idx, top_idx;

  // Entry count doubles as the write slot; the top sits one below it.
  assign wr_idx  = IDX_W'(cnt_q);
  assign top_idx = wr_idx - IDX_W'(1);
  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign top     = mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      cnt_d         = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pim_sequencer.sv
// rtl/pim_sequencer.sv - program sequencer: fetch, branch, call/return, loop, wait and EXEC hand-off
module pim_sequencer
  import pim_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int INSTR_W     = 6 + ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [2:0]         cond_sel,
  input  logic               cond,
  output logic               exec_valid,
  output logic [INSTR_W-1:0] exec_instr,
  input  logic               exec_done,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  pc
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d, pc_inc;
  logic [ADDR_W-1:0]    loop_cnt_q, loop_cnt_d;
  logic [ADDR_W-1:0]    loop_start_q, loop_start_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic                 exec_valid_q, exec_valid_d;
  logic [INSTR_W-1:0]   exec_instr_q, exec_instr_d;
  logic [2:0]           wait_sel_q, wait_sel_d;

  op_e                  op;
  logic [2:0]           sel;
  logic [ADDR_W-1:0]    arg;
  logic                 push, pop;
  logic                 stk_full, stk_empty;
  logic [ADDR_W-1:0]    stk_top;

  assign op         = op_e'(imem_rdata[OP_MSB:OP_LSB]);
  assign sel        = imem_rdata[SEL_MSB:SEL_LSB];
  assign arg        = imem_rdata[INSTR_W-1:ARG_LSB];
  assign pc_inc     = pc_q + ADDR_W'(1);

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign exec_valid = exec_valid_q;
  assign exec_instr = exec_instr_q;

  pim_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    busy_d       = busy_q;
    error_d      = error_q;
    exec_valid_d = exec_valid_q;
    exec_instr_d = exec_instr_q;
    wait_sel_d   = wait_sel_q;
    loop_cnt_d   = loop_cnt_q;
    loop_start_d = loop_start_q;
    push         = 1'b0;
    pop          = 1'b0;
    imem_en      = 1'b0;
    done         = 1'b0;
    cond_sel     = SEL_ALWAYS;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_en = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        // Most opcodes fall through to pc+1 and refetch; the rest override below.
        cond_sel = sel;
        state_d  = ST_FETCH;
        pc_d     = pc_inc;
        case (op)
          OP_EXEC: begin
            exec_valid_d = 1'b1;
            exec_instr_d = imem_rdata;
            pc_d         = pc_q;
            state_d      = ST_EXEC_WAIT;
          end
          OP_JMP: begin
            if (cond) pc_d = arg;
          end
          OP_CALL: begin
            if (cond) begin
              if (stk_full) begin
                pc_d    = pc_q;
                error_d = 1'b1;
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end else begin
                push = 1'b1;
                pc_d = arg;
              end
            end
          end
          OP_RET: begin
            if (cond) begin
              if (stk_empty) begin
                pc_d    = pc_q;
                error_d = 1'b1;
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end else begin
                pop  = 1'b1;
                pc_d = stk_top;
              end
            end
          end
          OP_LOOP: begin
            loop_cnt_d   = (arg == '0) ? ADDR_W'(1) : arg;
            loop_start_d = pc_inc;
          end
          OP_ENDLOOP: begin
            if (loop_cnt_q > ADDR_W'(1)) begin
              loop_cnt_d = loop_cnt_q - ADDR_W'(1);
              pc_d       = loop_start_q;
            end else begin
              loop_cnt_d = '0;
            end
          end
          OP_WAIT: begin
            pc_d       = pc_q;
            wait_sel_d = sel;
            state_d    = ST_WAIT_COND;
          end
          OP_HALT: begin
            pc_d    = pc_q;
            done    = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end

      ST_EXEC_WAIT: begin
        if (exec_done) begin
          exec_valid_d = 1'b0;
          pc_d         = pc_inc;
          state_d      = ST_FETCH;
        end
      end

      ST_WAIT_COND: begin
        cond_sel = wait_sel_q;
        if (cond) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      exec_valid_q <= 1'b0;
      exec_instr_q <= '0;
      wait_sel_q   <= SEL_ALWAYS;
      loop_cnt_q   <= '0;
      loop_start_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      exec_valid_q <= exec_valid_d;
      exec_instr_q <= exec_instr_d;
      wait_sel_q   <= wait_sel_d;
      loop_cnt_q   <= loop_cnt_d;
      loop_start_q <= loop_start_d;
    end
  end

endmodule

// File: tb/tb_pim_sequencer.sv
// tb/tb_pim_sequencer.sv - self-checking bench for pim_sequencer
module tb_pim_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [13:0] imem_rdata;
  logic [2:0]  cond_sel;
  logic        cond;
  logic        exec_valid;
  logic [13:0] exec_instr;
  logic        exec_done;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  pc;

  logic [13:0] imem [256];
  logic [7:0]  flags;
  logic [7:0]  fetch_q [$];
  logic [13:0] exec_q [$];
  logic [13:0] mexec_q [$];
  int          valid_cycles;
  int          unstable;
  bit          poke;
  int          n_cmp;
  int          n_bad;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= imem[imem_addr];
  assign cond = flags[cond_sel];

  pim_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .cond_sel   (cond_sel),
    .cond       (cond),
    .exec_valid (exec_valid),
    .exec_instr (exec_instr),
    .exec_done  (exec_done),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .pc         (pc)
  );

  function automatic logic [13:0] mk(input logic [2:0] op, input logic [2:0] sel, input logic [7:0] arg);
    return {arg, sel, op};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) imem[i] = mk(3'd7, 3'd0, 8'h00);
    flags = 8'h80;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; exec_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one program to completion, acting as the datapath with a fixed latency.
  task automatic run_prog(input logic [7:0] saddr, input int lat, output int cycles, output bit to);
    int vcnt;
    logic [13:0] held;
    fetch_q.delete(); exec_q.delete();
    valid_cycles = 0; unstable = 0; vcnt = 0; to = 1'b1; cycles = 0; held = '0;
    @(negedge clk);
    start = 1'b1; start_addr = saddr;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (imem_en) fetch_q.push_back(imem_addr);
      if (exec_valid) begin
        if (vcnt == 0) begin
          exec_q.push_back(exec_instr);
          held = exec_instr;
        end else if (exec_instr !== held) begin
          unstable++;
        end
        vcnt++;
        valid_cycles++;
        exec_done  = (vcnt == lat + 1);
        start      = poke && (vcnt == 2);
        start_addr = poke ? 8'h00 : saddr;
      end else begin
        vcnt = 0; exec_done = 1'b0; start = 1'b0;
      end
      if (done) begin
        cycles = c; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    exec_done = 1'b0; start = 1'b0;
  endtask

  // Instruction-level reference: walks the program and counts cycles per instruction class.
  task automatic model_run(input logic [7:0] saddr, input int lat, output int cycles,
                           output logic [7:0] fpc, output bit ferr, output bit ok);
    logic [7:0]  p, lc, ls, arg;
    logic [2:0]  op, sel;
    logic [13:0] w;
    logic [7:0]  stk [$];
    bit          c;
    p = saddr; lc = 8'd0; ls = 8'd0; cycles = 0; fpc = 8'd0; ferr = 1'b0; ok = 1'b0;
    mexec_q.delete();
    for (int s = 0; s < 100; s++) begin
      w = imem[p]; op = w[2:0]; sel = w[5:3]; arg = w[13:6]; c = flags[sel];
      cycles += 2;
      case (op)
        3'd0: begin mexec_q.push_back(w); cycles += lat + 1; p = p + 8'd1; end
        3'd1: p = c ? arg : p + 8'd1;
        3'd2: if (!c) p = p + 8'd1;
              else if (stk.size() == 4) begin ferr = 1'b1; fpc = p; ok = 1'b1; return; end
              else begin stk.push_back(p + 8'd1); p = arg; end
        3'd3: if (!c) p = p + 8'd1;
              else if (stk.size() == 0) begin ferr = 1'b1; fpc = p; ok = 1'b1; return; end
              else p = stk.pop_back();
        3'd4: begin lc = (arg == 8'd0) ? 8'd1 : arg; ls = p + 8'd1; p = p + 8'd1; end
        3'd5: if (lc > 8'd1) begin lc = lc - 8'd1; p = ls; end
              else begin lc = 8'd0; p = p + 8'd1; end
        3'd6: begin cycles += 1; p = p + 8'd1; end
        default: begin fpc = p; ok = 1'b1; return; end
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({imem_en, exec_valid, busy, done, error} !== 5'b0) begin n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {imem_en, exec_valid, busy, done, error}); end
    n_cmp++; if (cond_sel !== 3'b111) begin n_bad++; $display("FAIL reset_cond_sel: got %0d want 7", cond_sel); end
    n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_cmp++; if (exec_instr !== 14'h0) begin n_bad++; $display("FAIL reset_exec_instr: got %h want 0", exec_instr); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_halt();
    fill_halt();
    @(negedge clk);
    start = 1'b1; start_addr = 8'h10;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({imem_en, imem_addr, busy, done} !== {1'b1, 8'h10, 1'b1, 1'b0}) begin n_bad++;
      $display("FAIL halt_fetch: got en=%b addr=%h busy=%b done=%b want 1 10 1 0", imem_en, imem_addr, busy, done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL halt_done: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL halt_after: got done=%b busy=%b want 0 0", done, busy); end
    n_cmp++; if (pc !== 8'h10) begin n_bad++; $display("FAIL halt_pc: got %h want 10", pc); end
  endtask

  task automatic test_jmp();
    int cyc; bit to; logic [7:0] exp, got;
    for (int k = 0; k < 3; k++) begin
      do_reset(); fill_halt();
      flags = (k == 1) ? 8'h84 : 8'h80;
      imem[8'h10] = mk(3'd1, (k == 2) ? 3'd7 : 3'd2, 8'h40);
      run_prog(8'h10, 0, cyc, to);
      @(negedge clk);
      exp = (k == 0) ? 8'h11 : 8'h40;
      got = (fetch_q.size() > 1) ? fetch_q[1] : 8'hxx;
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL jmp%0d_timeout: got timeout want done", k); end
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL jmp%0d_fetch: got %h want %h", k, got, exp); end
      n_cmp++; if (pc !== exp) begin n_bad++; $display("FAIL jmp%0d_pc: got %h want %h", k, pc, exp); end
      n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL jmp%0d_cycles: got %0d want 4", k, cyc); end
    end
  endtask

  task automatic test_call_ret();
    int cyc; bit to; logic [7:0] got;
    do_reset(); fill_halt();
    imem[8'h05] = mk(3'd2, 3'd7, 8'h30);
    imem[8'h30] = mk(3'd3, 3'd7, 8'h00);
    run_prog(8'h05, 0, cyc, to);
    @(negedge clk);
    got = (fetch_q.size() > 2) ? fetch_q[2] : 8'hxx;
    n_cmp++; if (got !== 8'h06) begin n_bad++; $display("FAIL ret_fetch: got %h want 06", got); end
    n_cmp++; if ({error, pc} !== {1'b0, 8'h06}) begin n_bad++; $display("FAIL ret_end: got err=%b pc=%h want 0 06", error, pc); end
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL ret_cycles: got %0d want 6", cyc); end

    do_reset(); fill_halt();
    for (int i = 0; i < 5; i++) imem[8'h60 + i] = mk(3'd2, 3'd7, 8'(8'h61 + i));
    run_prog(8'h60, 0, cyc, to);
    @(negedge clk);
    n_cmp++; if ({to, error, busy} !== 3'b010) begin n_bad++; $display("FAIL overflow_flags: got to=%b err=%b busy=%b want 0 1 0", to, error, busy); end
    n_cmp++; if (pc !== 8'h64) begin n_bad++; $display("FAIL overflow_pc: got %h want 64", pc); end
    n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL overflow_cycles: got %0d want 10", cyc); end

    do_reset(); fill_halt();
    imem[8'h70] = mk(3'd3, 3'd7, 8'h00);
    run_prog(8'h70, 0, cyc, to);
    @(negedge clk);
    n_cmp++; if ({to, error, pc} !== {1'b0, 1'b1, 8'h70}) begin n_bad++; $display("FAIL underflow: got to=%b err=%b pc=%h want 0 1 70", to, error, pc); end
    run_prog(8'h10, 0, cyc, to);
    @(negedge clk);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL error_clear: got %b want 0", error); end
  endtask

  task automatic test_loop();
    int cyc, n; bit to; logic [7:0] cnt;
    for (int k = 0; k < 2; k++) begin
      cnt = (k == 0) ? 8'd3 : 8'd0;
      n = (k == 0) ? 3 : 1;
      do_reset(); fill_halt();
      imem[8'h80] = mk(3'd4, 3'd0, cnt);
      imem[8'h81] = mk(3'd0, 3'd0, 8'hAB);
      imem[8'h82] = mk(3'd5, 3'd0, 8'h00);
      run_prog(8'h80, 1, cyc, to);
      @(negedge clk);
      n_cmp++; if (exec_q.size() !== n) begin n_bad++; $display("FAIL loop%0d_handshakes: got %0d want %0d", cnt, exec_q.size(), n); end
      n_cmp++; if (pc !== 8'h83) begin n_bad++; $display("FAIL loop%0d_pc: got %h want 83", cnt, pc); end
      n_cmp++; if (cyc !== 4 + 6 * n) begin n_bad++; $display("FAIL loop%0d_cycles: got %0d want %0d", cnt, cyc, 4 + 6 * n); end
    end
  endtask

  task automatic test_exec_latency();
    int cyc; bit to; logic [13:0] got;
    do_reset(); fill_halt();
    imem[8'h90] = mk(3'd0, 3'd3, 8'h5A);
    poke = 1'b1;
    run_prog(8'h90, 4, cyc, to);
    poke = 1'b0;
    @(negedge clk);
    got = (exec_q.size() > 0) ? exec_q[0] : 14'hxxxx;
    n_cmp++; if (valid_cycles !== 5) begin n_bad++; $display("FAIL exec_valid_len: got %0d want 5", valid_cycles); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL exec_stable: got %0d changes want 0", unstable); end
    n_cmp++; if (got !== mk(3'd0, 3'd3, 8'h5A)) begin n_bad++; $display("FAIL exec_instr: got %h want %h", got, mk(3'd0, 3'd3, 8'h5A)); end
    n_cmp++; if ({pc, cyc[7:0]} !== {8'h91, 8'd9}) begin n_bad++; $display("FAIL exec_end: got pc=%h cyc=%0d want 91 9", pc, cyc); end
    exec_done = 1'b1;
    repeat (3) @(negedge clk);
    exec_done = 1'b0;
    n_cmp++; if ({exec_valid, busy, pc} !== {2'b00, 8'h91}) begin n_bad++;
      $display("FAIL stray_done: got valid=%b busy=%b pc=%h want 0 0 91", exec_valid, busy, pc); end
  endtask

  task automatic test_wait();
    int n4, fc, dc; logic [7:0] fa;
    do_reset(); fill_halt();
    imem[8'h20] = mk(3'd6, 3'd4, 8'h00);
    n4 = 0; fc = 0; dc = 0; fa = 8'h00;
    @(negedge clk);
    start = 1'b1; start_addr = 8'h20;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (cond_sel == 3'd4) n4++;
      if (imem_en && c > 1 && fc == 0) begin fc = c; fa = imem_addr; end
      if (c == 9) flags[4] = 1'b1;
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++; if (n4 !== 8) begin n_bad++; $display("FAIL wait_sel_cycles: got %0d want 8", n4); end
    n_cmp++; if ({fc[7:0], fa} !== {8'd10, 8'h21}) begin n_bad++; $display("FAIL wait_exit_fetch: got cyc=%0d addr=%h want 10 21", fc, fa); end
    n_cmp++; if (dc !== 11) begin n_bad++; $display("FAIL wait_done_cycle: got %0d want 11", dc); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset(); fill_halt();
    imem[8'h50] = mk(3'd0, 3'd0, 8'h11);
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = 8'h50;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (exec_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_exec: got %b want 1", seen); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({exec_valid, busy, cond_sel, pc} !== {2'b00, 3'b111, 8'h00}) begin n_bad++;
      $display("FAIL midrst_immediate: got valid=%b busy=%b sel=%0d pc=%h want 0 0 7 00", exec_valid, busy, cond_sel, pc); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({exec_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_stays_idle: got valid=%b busy=%b want 0 0", exec_valid, busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [7:0] base, mpc, tgt;
      logic [2:0] op, sel;
      int lat, mcyc, dcyc;
      bit merr, ok, to;
      ok = 1'b0; base = 8'h00; lat = 0; mcyc = 0; mpc = 8'h00; merr = 1'b0;
      for (int t = 0; t < 30 && !ok; t++) begin
        base = 8'($urandom);
        lat = $urandom_range(0, 3);
        fill_halt();
        flags = {1'b1, 7'($urandom)};
        for (int i = 0; i < 24; i++) begin
          op  = 3'($urandom_range(0, 7));
          sel = 3'($urandom_range(0, 7));
          tgt = base + 8'($urandom_range(0, 23));
          if (op == 3'd4) tgt = 8'($urandom_range(0, 3));
          if (op == 3'd0) tgt = 8'($urandom);
          if (op == 3'd6 && !flags[sel]) sel = 3'd7;
          imem[8'(base + i)] = mk(op, sel, tgt);
        end
        model_run(base, lat, mcyc, mpc, merr, ok);
      end
      if (!ok) continue;
      do_reset();
      run_prog(base, lat, dcyc, to);
      @(negedge clk);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout: got timeout want done", n); end
      n_cmp++; if (dcyc !== mcyc) begin n_bad++; $display("FAIL rnd%0d_cycles: got %0d want %0d", n, dcyc, mcyc); end
      n_cmp++; if (pc !== mpc) begin n_bad++; $display("FAIL rnd%0d_pc: got %h want %h", n, pc, mpc); end
      n_cmp++; if ({error, busy} !== {merr, 1'b0}) begin n_bad++; $display("FAIL rnd%0d_status: got err=%b busy=%b want %b 0", n, error, busy, merr); end
      n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL rnd%0d_stable: got %0d changes want 0", n, unstable); end
      n_cmp++; if (exec_q.size() !== mexec_q.size()) begin n_bad++;
        $display("FAIL rnd%0d_exec_count: got %0d want %0d", n, exec_q.size(), mexec_q.size()); end
      else begin
        for (int i = 0; i < exec_q.size(); i++) begin
          n_cmp++; if (exec_q[i] !== mexec_q[i]) begin n_bad++; $display("FAIL rnd%0d_exec%0d: got %h want %h", n, i, exec_q[i], mexec_q[i]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = 8'h00; exec_done = 1'b0;
    flags = 8'h80; poke = 1'b0; n_cmp = 0; n_bad = 0;
    test_reset();
    test_halt();
    test_jmp();
    test_call_ret();
    test_loop();
    test_exec_latency();
    test_wait();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
